// File: rtl/iob_fifo2p_asym.sv
// Asymmetric-width synchronous FIFO controller driving an external split-bank
// two-port RAM. It keeps pointers, occupancy and flags in MINDATA_W units.
// The lowest-addressed unit sits in the LSBs of the wide word.
module iob_fifo2p_asym #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 10,
  localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W,
  localparam int N         = MAXDATA_W / MINDATA_W,
  localparam int MINADDR_W = ADDR_W - $clog2(N),
  localparam int W_RATIO   = W_DATA_W / MINDATA_W,
  localparam int R_RATIO   = R_DATA_W / MINDATA_W
) (
  input  logic                      ap_clk,
  input  logic                      areset,
  input  logic                      w_en,
  input  logic [W_DATA_W-1:0]       w_data,
  output logic                      w_full,
  output logic                      w_err,
  input  logic                      r_en,
  output logic [R_DATA_W-1:0]       r_data,
  output logic                      r_valid,
  output logic                      r_empty,
  output logic                      r_err,
  output logic [ADDR_W:0]           level,
  output logic [N-1:0]              ext_mem_w_en,
  output logic [MINADDR_W*N-1:0]    ext_mem_w_addr,
  output logic [MINDATA_W*N-1:0]    ext_mem_w_data,
  output logic                      ext_mem_r_en,
  output logic [MINADDR_W*N-1:0]    ext_mem_r_addr,
  input  logic [MINDATA_W*N-1:0]    ext_mem_r_data
);

  localparam int LOG2N = $clog2(N);
  localparam logic [ADDR_W:0] W_STEP   = (ADDR_W+1)'(W_RATIO);
  localparam logic [ADDR_W:0] R_STEP   = (ADDR_W+1)'(R_RATIO);
  localparam logic [ADDR_W:0] FULL_THR = (ADDR_W+1)'((1 << ADDR_W) - W_RATIO);

  logic [ADDR_W:0]     wptr, rptr;
  logic [ADDR_W:0]     wptr_nxt, rptr_nxt, level_nxt;
  logic                w_acc, r_acc;
  logic                r_valid_q;
  logic [R_DATA_W-1:0] r_word;

  // Requests are ignored while reset is held so the RAM sees no access.
  assign w_acc = w_en & ~w_full & ~areset;
  assign r_acc = r_en & ~r_empty & ~areset;

  assign ext_mem_r_en = r_acc;

  // A read in flight when reset arrives must never surface as r_valid.
  assign r_valid = r_valid_q & ~areset;
  assign r_data  = r_valid ? r_word : '0;

  // Next pointer values and the occupancy they imply.
  always_comb begin
    wptr_nxt  = w_acc ? wptr + W_STEP : wptr;
    rptr_nxt  = r_acc ? rptr + R_STEP : rptr;
    level_nxt = wptr_nxt - rptr_nxt;
  end

  // Pointer, occupancy, flag and error-pulse registers.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      w_full    <= 1'b0;
      r_empty   <= 1'b1;
      w_err     <= 1'b0;
      r_err     <= 1'b0;
      r_valid_q <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      level     <= level_nxt;
      w_full    <= level_nxt > FULL_THR;
      r_empty   <= level_nxt < R_STEP;
      w_err     <= w_en & w_full;
      r_err     <= r_en & r_empty;
      r_valid_q <= r_acc;
    end
  end

  if (W_DATA_W > R_DATA_W) begin : g_wide_write
    logic [LOG2N-1:0] r_sel;

    // Bank holding the requested narrow unit, captured with the read request.
    always_ff @(posedge ap_clk) begin
      if (areset) begin
        r_sel <= '0;
      end else if (r_acc) begin
        r_sel <= rptr[LOG2N-1:0];
      end
    end

    // Full-width writes hit every bank; reads fetch a row and pick one lane.
    always_comb begin
      ext_mem_w_en   = {N{w_acc}};
      ext_mem_w_data = w_data;
      ext_mem_w_addr = '0;
      ext_mem_r_addr = '0;
      for (int unsigned i = 0; i < N; i++) begin
        ext_mem_w_addr[i*MINADDR_W +: MINADDR_W] = wptr[ADDR_W-1:LOG2N];
        ext_mem_r_addr[i*MINADDR_W +: MINADDR_W] = rptr[ADDR_W-1:LOG2N];
      end
      r_word = ext_mem_r_data[r_sel*MINDATA_W +: MINDATA_W];
    end
  end else if (W_DATA_W < R_DATA_W) begin : g_wide_read
    // Narrow writes go to one bank by pointer LSBs; reads gather all banks.
    always_comb begin
      ext_mem_w_en   = {{(N-1){1'b0}}, w_acc} << wptr[LOG2N-1:0];
      ext_mem_w_data = {N{w_data}};
      ext_mem_w_addr = '0;
      ext_mem_r_addr = '0;
      for (int unsigned i = 0; i < N; i++) begin
        ext_mem_w_addr[i*MINADDR_W +: MINADDR_W] = wptr[ADDR_W-1:LOG2N];
        ext_mem_r_addr[i*MINADDR_W +: MINADDR_W] = rptr[ADDR_W-1:LOG2N];
      end
      r_word = ext_mem_r_data;
    end
  end else begin : g_equal
    // Single bank, straight-through mapping.
    always_comb begin
      ext_mem_w_en   = w_acc;
      ext_mem_w_data = w_data;
      ext_mem_w_addr = wptr[ADDR_W-1:0];
      ext_mem_r_addr = rptr[ADDR_W-1:0];
      r_word         = ext_mem_r_data;
    end
  end

endmodule
